// File: rtl/axis_mac_pipe.sv
// axis_mac_pipe: joins A/B/C AXI-Stream operands and emits A*B+C per beat or summed per packet.
// Two register stages (product, output) with full backpressure and optional signed/saturating arithmetic.
module axis_mac_pipe #(
    parameter int A_W    = 8,
    parameter int B_W    = 8,
    parameter int C_W    = 8,
    parameter int OUT_W  = 18,
    parameter int SIGNED = 0,
    parameter int SAT    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic [A_W-1:0]   s_tdata_operand_a,
    input  logic             s_tvalid_operand_a,
    output logic             s_tready_operand_a,
    input  logic             s_tlast_operand_a,
    input  logic [B_W-1:0]   s_tdata_operand_b,
    input  logic             s_tvalid_operand_b,
    output logic             s_tready_operand_b,
    input  logic             s_tlast_operand_b,
    input  logic [C_W-1:0]   s_tdata_operand_c,
    input  logic             s_tvalid_operand_c,
    output logic             s_tready_operand_c,
    input  logic             s_tlast_operand_c,
    output logic [OUT_W-1:0] m_tdata_result,
    output logic             m_tvalid_result,
    input  logic             m_tready_result,
    output logic             m_tlast_result,
    output logic             tlast_err
);
    localparam int P_W = A_W + B_W;
    localparam int X_W = P_W > OUT_W ? P_W : OUT_W;
    localparam int S_W = (X_W > C_W ? X_W : C_W) + 2;
    localparam bit SG = SIGNED != 0;
    localparam bit CLAMP = SAT != 0;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] PKT = 1'b1;

    logic [0:0]     state;
    logic           pkt_mode, v1, l1, m1, sticky;
    logic [P_W-1:0] a_e, b_e, prod, p1;
    logic [C_W-1:0] c1;
    logic [OUT_W-1:0] acc, lim, res;
    logic [S_W-1:0] sum;
    logic           all_v, st1_ready, st2_ready, hs, adv, emit, ovf, clip;

    assign all_v = s_tvalid_operand_a & s_tvalid_operand_b & s_tvalid_operand_c;
    assign st2_ready = !m_tvalid_result | m_tready_result;
    assign st1_ready = !v1 | st2_ready;
    assign hs = all_v & st1_ready & !rst;
    assign s_tready_operand_a = hs;
    assign s_tready_operand_b = hs;
    assign s_tready_operand_c = hs;
    assign adv = v1 & st2_ready;
    assign emit = !m1 | l1;

    // Extending both operands to the full product width makes one multiplier serve both signednesses.
    assign a_e = {{B_W{SG & s_tdata_operand_a[A_W-1]}}, s_tdata_operand_a};
    assign b_e = {{A_W{SG & s_tdata_operand_b[B_W-1]}}, s_tdata_operand_b};
    assign prod = a_e * b_e;

    assign sum = {{(S_W-P_W){SG & p1[P_W-1]}}, p1}
               + {{(S_W-C_W){SG & c1[C_W-1]}}, c1}
               + (m1 ? {{(S_W-OUT_W){SG & acc[OUT_W-1]}}, acc} : {S_W{1'b0}});
    assign ovf = SG ? !((&sum[S_W-1:OUT_W-1]) | ~(|sum[S_W-1:OUT_W-1])) : |sum[S_W-1:OUT_W];
    assign clip = CLAMP & ovf;
    assign lim = !SG ? {OUT_W{1'b1}} : sum[S_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    // Once a packet has clipped, the accumulator freezes at the clamp value until its last beat.
    assign res = (m1 & sticky) ? acc : clip ? lim : sum[OUT_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            pkt_mode <= 1'b0;
            v1 <= 1'b0;
            p1 <= '0;
            c1 <= '0;
            l1 <= 1'b0;
            m1 <= 1'b0;
            tlast_err <= 1'b0;
        end else begin
            if (st1_ready) v1 <= hs;
            if (hs) begin
                p1 <= prod;
                c1 <= s_tdata_operand_c;
                l1 <= s_tlast_operand_a;
                m1 <= state == PKT ? pkt_mode : mode;
                state <= s_tlast_operand_a ? IDLE : PKT;
                if (state == IDLE) pkt_mode <= mode;
            end
            tlast_err <= hs & ((s_tlast_operand_b != s_tlast_operand_a) | (s_tlast_operand_c != s_tlast_operand_a));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_tvalid_result <= 1'b0;
            m_tdata_result <= '0;
            m_tlast_result <= 1'b0;
            acc <= '0;
            sticky <= 1'b0;
        end else begin
            if (st2_ready) m_tvalid_result <= adv & emit;
            if (adv & emit) begin
                m_tdata_result <= res;
                m_tlast_result <= l1;
            end
            if (adv & m1) begin
                acc <= l1 ? '0 : res;
                sticky <= !l1 & (sticky | clip);
            end
        end
    end
endmodule

// File: tb/tb_axis_mac_pipe.sv
// tb_axis_mac_pipe: directed vector table plus randomized joined streams checked against a packet-level model.
module tb_axis_mac_pipe;
    localparam int MAXU = 262143;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mode = 1'b0;
    logic [7:0] sa = '0, sb = '0, sc = '0;
    logic va_i = 1'b0, vb_i = 1'b0, vc_i = 1'b0;
    logic la_i = 1'b0, lb_i = 1'b0, lc_i = 1'b0;
    logic m_tready = 1'b1;
    logic ra, rb, rc, m_tvalid, m_tlast, terr;
    logic [17:0] m_tdata;
    logic ss_ra, ss_rb, ss_rc, ss_v, ss_l, ss_e, sw_ra, sw_rb, sw_rc, sw_v, sw_l, sw_e;
    logic [7:0] ss_d, sw_d;

    always #5 clk = ~clk;

    axis_mac_pipe u_dut (
        .clk(clk), .rst(rst), .mode(mode),
        .s_tdata_operand_a(sa), .s_tvalid_operand_a(va_i), .s_tready_operand_a(ra), .s_tlast_operand_a(la_i),
        .s_tdata_operand_b(sb), .s_tvalid_operand_b(vb_i), .s_tready_operand_b(rb), .s_tlast_operand_b(lb_i),
        .s_tdata_operand_c(sc), .s_tvalid_operand_c(vc_i), .s_tready_operand_c(rc), .s_tlast_operand_c(lc_i),
        .m_tdata_result(m_tdata), .m_tvalid_result(m_tvalid), .m_tready_result(m_tready),
        .m_tlast_result(m_tlast), .tlast_err(terr));

    axis_mac_pipe #(.OUT_W(8), .SIGNED(1), .SAT(1)) u_ss (
        .clk(clk), .rst(rst), .mode(mode),
        .s_tdata_operand_a(sa), .s_tvalid_operand_a(va_i), .s_tready_operand_a(ss_ra), .s_tlast_operand_a(la_i),
        .s_tdata_operand_b(sb), .s_tvalid_operand_b(vb_i), .s_tready_operand_b(ss_rb), .s_tlast_operand_b(lb_i),
        .s_tdata_operand_c(sc), .s_tvalid_operand_c(vc_i), .s_tready_operand_c(ss_rc), .s_tlast_operand_c(lc_i),
        .m_tdata_result(ss_d), .m_tvalid_result(ss_v), .m_tready_result(m_tready),
        .m_tlast_result(ss_l), .tlast_err(ss_e));

    axis_mac_pipe #(.OUT_W(8), .SIGNED(1), .SAT(0)) u_sw (
        .clk(clk), .rst(rst), .mode(mode),
        .s_tdata_operand_a(sa), .s_tvalid_operand_a(va_i), .s_tready_operand_a(sw_ra), .s_tlast_operand_a(la_i),
        .s_tdata_operand_b(sb), .s_tvalid_operand_b(vb_i), .s_tready_operand_b(sw_rb), .s_tlast_operand_b(lb_i),
        .s_tdata_operand_c(sc), .s_tvalid_operand_c(vc_i), .s_tready_operand_c(sw_rc), .s_tlast_operand_c(lc_i),
        .m_tdata_result(sw_d), .m_tvalid_result(sw_v), .m_tready_result(m_tready),
        .m_tlast_result(sw_l), .tlast_err(sw_e));

    typedef struct {
        bit md; int a; int b; int c; bit la; bit lb; bit lc;
        bit fixed; bit ev; int ed; bit sg; int ds; int dw;
    } beat_t;
    typedef struct { int d; bit l; bit sg; int ds; int dw; } exp_t;

    beat_t bq[$];
    beat_t tbl[$];
    exp_t eq[$];
    beat_t cur;
    bit have = 0, va = 0, vb = 0, vc = 0, rnd = 0;
    int hold_c = 0;
    bit in_pkt = 0, pmode = 0, sticky = 0, err_exp = 0, stall_prev = 0, held_l = 0;
    int acc = 0, held_d = 0;
    int checks = 0, failures = 0;

    function automatic beat_t mk(bit md, int a, int b, int c, bit la, bit lb, bit lc, bit ev, int ed);
        beat_t t;
        t = '{md: md, a: a, b: b, c: c, la: la, lb: lb, lc: lc, fixed: 1'b1, ev: ev, ed: ed, sg: 1'b0, ds: 0, dw: 0};
        return t;
    endfunction

    function automatic beat_t mks(int a, int b, int c, int ed, int ds, int dw);
        beat_t t;
        t = mk(1'b0, a, b, c, 1'b1, 1'b1, 1'b1, 1'b1, ed);
        t.sg = 1'b1;
        t.ds = ds;
        t.dw = dw;
        return t;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Packet-level reference: products summed with clamp-and-freeze, emitted on A's last beat.
    task automatic model(input beat_t t);
        int val;
        bit emit_now;
        exp_t e;
        val = t.a * t.b + t.c;
        if (!in_pkt) pmode = t.md;
        emit_now = 1'b0;
        e = '{d: 0, l: t.la, sg: t.sg, ds: t.ds, dw: t.dw};
        if (!pmode) begin
            emit_now = 1'b1;
            e.d = val;
        end else begin
            if (!sticky) begin
                acc += val;
                if (acc > MAXU) begin
                    acc = MAXU;
                    sticky = 1'b1;
                end
            end
            if (t.la) begin
                emit_now = 1'b1;
                e.d = acc;
                acc = 0;
                sticky = 1'b0;
            end
        end
        if (t.fixed) begin
            emit_now = t.ev;
            e.d = t.ed;
        end
        if (emit_now) eq.push_back(e);
        in_pkt = !t.la;
    endtask

    task automatic cycle(input bit rdy);
        bit hs;
        exp_t e;
        @(negedge clk);
        if (!have && bq.size() > 0) begin
            cur = bq.pop_front();
            have = 1'b1;
            va = 1'b0;
            vb = 1'b0;
            vc = 1'b0;
        end
        if (have) begin
            va = va | (rnd ? 1'($urandom_range(1)) : 1'b1);
            vb = vb | (rnd ? 1'($urandom_range(1)) : 1'b1);
            vc = hold_c > 0 ? 1'b0 : (vc | (rnd ? 1'($urandom_range(1)) : 1'b1));
        end
        mode = cur.md;
        sa = 8'(cur.a);
        sb = 8'(cur.b);
        sc = 8'(cur.c);
        la_i = cur.la;
        lb_i = cur.lb;
        lc_i = cur.lc;
        va_i = have & va;
        vb_i = have & vb;
        vc_i = have & vc;
        m_tready = rdy;
        #1;
        chk("tlast_err", int'(terr), int'(err_exp));
        chk("ready_join", int'({rb, rc}), int'({ra, ra}));
        if (hold_c > 0) begin
            chk("ready_wait_c", int'(ra), 0);
            hold_c--;
        end
        if (stall_prev) begin
            chk("stall_valid", int'(m_tvalid), 1);
            chk("stall_data", int'(m_tdata), held_d);
            chk("stall_last", int'(m_tlast), int'(held_l));
        end
        if (m_tvalid) begin
            if (eq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_valid actual=%0d required=none at %0t", m_tdata, $time);
            end else if (m_tready) begin
                e = eq.pop_front();
                chk("result_data", int'(m_tdata), e.d);
                chk("result_last", int'(m_tlast), int'(e.l));
                if (e.sg) begin
                    chk("signed_sat", int'(ss_d), e.ds);
                    chk("signed_wrap", int'(sw_d), e.dw);
                end
            end
        end
        stall_prev = m_tvalid & !m_tready;
        held_d = int'(m_tdata);
        held_l = m_tlast;
        hs = ra & va_i & vb_i & vc_i;
        err_exp = hs & ((cur.lb != cur.la) | (cur.lc != cur.la));
        if (hs) begin
            model(cur);
            have = 1'b0;
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((bq.size() > 0 || have || eq.size() > 0) && n < budget) begin
            cycle(rnd ? ($urandom_range(3) != 0) : 1'b1);
            n++;
        end
        if (n >= budget) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d required=0 pending at %0t", eq.size() + bq.size(), $time);
        end
        for (int i = 0; i < 4; i++) cycle(1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        va_i = 1'b1;
        vb_i = 1'b1;
        vc_i = 1'b1;
        #1;
        chk("rst_ready", int'({ra, rb, rc}), 0);
        chk("rst_valid", int'(m_tvalid), 0);
        chk("rst_data", int'(m_tdata), 0);
        chk("rst_last", int'(m_tlast), 0);
        chk("rst_err", int'(terr), 0);
        @(negedge clk);
        rst = 1'b0;
        va_i = 1'b0;
        vb_i = 1'b0;
        vc_i = 1'b0;
        have = 1'b0;
        in_pkt = 1'b0;
        acc = 0;
        sticky = 1'b0;
        err_exp = 1'b0;
        stall_prev = 1'b0;
        eq.delete();
    endtask

    initial begin
        beat_t t;
        tbl.push_back(mk(0, 3, 4, 5, 1, 1, 1, 1, 17));
        tbl.push_back(mk(1, 2, 3, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4, 5, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 2, 1, 1, 1, 1, 30));
        tbl.push_back(mks(128, 128, 0, 16384, 127, 0));
        tbl.push_back(mks(253, 5, 2, 1267, 243, 243));
        tbl.push_back(mks(127, 127, 127, 16256, 127, 128));
        tbl.push_back(mks(128, 127, 128, 16384, 128, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 255, 255, 255, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 255, 255, 255, 1, 1, 1, 1, MAXU));
        tbl.push_back(mk(1, 1, 2, 3, 1, 1, 1, 1, 5));
        tbl.push_back(mk(0, 10, 10, 0, 0, 0, 0, 1, 100));
        tbl.push_back(mk(1, 1, 1, 1, 1, 1, 1, 1, 2));
        tbl.push_back(mk(0, 2, 2, 2, 1, 0, 1, 1, 6));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 1, 0));

        do_reset();
        for (int i = 0; i < tbl.size(); i++) bq.push_back(tbl[i]);
        drain(400);

        for (int i = 0; i < 4; i++) bq.push_back(mk(0, i + 1, 7, i, i == 3, i == 3, i == 3, 1, (i + 1) * 7 + i));
        cycle(1'b1);
        cycle(1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0);
        chk("bp_ready_low", int'(ra), 0);
        drain(100);

        hold_c = 3;
        bq.push_back(mk(0, 6, 7, 8, 1, 1, 1, 1, 50));
        drain(100);

        bq.push_back(mk(1, 5, 5, 5, 0, 0, 0, 0, 0));
        bq.push_back(mk(1, 5, 5, 5, 0, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++) cycle(1'b1);
        do_reset();
        bq.push_back(mk(1, 1, 1, 0, 1, 1, 1, 1, 1));
        bq.push_back(mk(0, 3, 3, 3, 1, 1, 0, 1, 12));
        drain(100);

        rnd = 1'b1;
        for (int i = 0; i < 400; i++) begin
            t.md = 1'($urandom_range(1));
            t.a = $urandom_range(7) == 0 ? 255 : int'($urandom_range(255));
            t.b = $urandom_range(7) == 0 ? 255 : int'($urandom_range(255));
            t.c = int'($urandom_range(255));
            t.la = i == 399 ? 1'b1 : ($urandom_range(2) == 0);
            t.lb = $urandom_range(15) == 0 ? !t.la : t.la;
            t.lc = $urandom_range(15) == 0 ? !t.la : t.la;
            t.fixed = 1'b0;
            t.ev = 1'b0;
            t.ed = 0;
            t.sg = 1'b0;
            t.ds = 0;
            t.dw = 0;
            bq.push_back(t);
        end
        drain(20000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
